// File: rtl/alt_dfe_pkg.sv
// alt_dfe_pkg: state encoding, default widths and sizing helper for the DFE IR arbiter
package alt_dfe_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam int DEF_CHADDR_WIDTH   = 16;
    localparam int DEF_WDADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1023;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/alt_dfe_rr_pick.sv
// alt_dfe_rr_pick: combinational round-robin picker, first request after i_last wins
module alt_dfe_rr_pick import alt_dfe_pkg::*; #(
    parameter int NUM_REQ = 2,
    localparam int IW = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic               o_valid,
    output logic [IW-1:0]      o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);
    int j;
    always_comb begin
        j        = 0;
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        // scan farthest-first so the nearest candidate after i_last overrides
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(i_last) + k) % NUM_REQ;
            if (i_req[j]) begin
                o_valid  = 1'b1;
                o_idx    = IW'(j);
                o_onehot = NUM_REQ'(1) << j;
            end
        end
    end
endmodule

// File: rtl/alt_dfe_ir_arbiter.sv
// alt_dfe_ir_arbiter: round-robin sharing of the DFE AVMM master command port, one op in flight with watchdog
module alt_dfe_ir_arbiter import alt_dfe_pkg::*; #(
    parameter int NUM_REQ           = 2,
    parameter int IREG_CHADDR_WIDTH = DEF_CHADDR_WIDTH,
    parameter int IREG_WDADDR_WIDTH = DEF_WDADDR_WIDTH,
    parameter int IREG_DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic                                   i_avmm_clk,
    input  logic                                   i_resetn,
    input  logic [NUM_REQ-1:0]                     i_req,
    input  logic [NUM_REQ*IREG_CHADDR_WIDTH-1:0]   i_chaddress,
    input  logic [NUM_REQ*IREG_WDADDR_WIDTH-1:0]   i_wdaddress,
    input  logic [NUM_REQ*IREG_DATA_WIDTH-1:0]     i_writedata,
    input  logic [NUM_REQ-1:0]                     i_rwn,
    output logic [NUM_REQ-1:0]                     o_ack,
    output logic                                   o_error,
    output logic [IREG_DATA_WIDTH-1:0]             o_readdata,
    output logic [NUM_REQ-1:0]                     o_grant,
    output logic                                   o_busy,
    output logic                                   o_ir_trigger,
    output logic [IREG_CHADDR_WIDTH-1:0]           o_ir_chaddress,
    output logic [IREG_WDADDR_WIDTH-1:0]           o_ir_wdaddress,
    output logic [IREG_DATA_WIDTH-1:0]             o_ir_writedata,
    output logic                                   o_ir_rwn,
    input  logic                                   i_ir_done,
    input  logic [IREG_DATA_WIDTH-1:0]             i_ir_readdata
);
    localparam int IW = clog2_min1(NUM_REQ);
    localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    state_t                         state;
    logic [IW-1:0]                  last;
    logic [TW-1:0]                  timer;
    logic                           pick_valid;
    logic [IW-1:0]                  pick_idx;
    logic [NUM_REQ-1:0]             pick_onehot;
    logic [IREG_CHADDR_WIDTH-1:0]   sel_ch;
    logic [IREG_WDADDR_WIDTH-1:0]   sel_wd;
    logic [IREG_DATA_WIDTH-1:0]     sel_data;
    logic                           sel_rwn;
    logic                           timeout;
    alt_dfe_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req    (i_req),
        .i_last   (last),
        .o_valid  (pick_valid),
        .o_idx    (pick_idx),
        .o_onehot (pick_onehot)
    );
    always_comb begin
        sel_ch   = '0;
        sel_wd   = '0;
        sel_data = '0;
        sel_rwn  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_onehot[k]) begin
                sel_ch   = i_chaddress[k*IREG_CHADDR_WIDTH +: IREG_CHADDR_WIDTH];
                sel_wd   = i_wdaddress[k*IREG_WDADDR_WIDTH +: IREG_WDADDR_WIDTH];
                sel_data = i_writedata[k*IREG_DATA_WIDTH +: IREG_DATA_WIDTH];
                sel_rwn  = i_rwn[k];
            end
        end
    end
    assign timeout = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);
    always_ff @(posedge i_avmm_clk) begin
        if (!i_resetn) begin
            state          <= ST_IDLE;
            last           <= IW'(NUM_REQ - 1);
            timer          <= '0;
            o_ack          <= '0;
            o_error        <= 1'b0;
            o_readdata     <= '0;
            o_grant        <= '0;
            o_busy         <= 1'b0;
            o_ir_trigger   <= 1'b0;
            o_ir_chaddress <= '0;
            o_ir_wdaddress <= '0;
            o_ir_writedata <= '0;
            o_ir_rwn       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        last           <= pick_idx;
                        o_grant        <= pick_onehot;
                        o_busy         <= 1'b1;
                        o_ir_trigger   <= 1'b1;
                        o_ir_chaddress <= sel_ch;
                        o_ir_wdaddress <= sel_wd;
                        o_ir_writedata <= sel_data;
                        o_ir_rwn       <= sel_rwn;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_ir_trigger <= 1'b0;
                    timer        <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= (timer == '1) ? timer : timer + 1'b1;
                    // a done arriving on the watchdog's last cycle still counts as a normal completion
                    if (i_ir_done || timeout) begin
                        o_readdata <= i_ir_done ? i_ir_readdata : '0;
                        o_error    <= !i_ir_done;
                        o_ack      <= o_grant;
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    o_ack   <= '0;
                    o_grant <= '0;
                    o_error <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alt_dfe_ir_arbiter.sv
// tb_alt_dfe_ir_arbiter: directed vector table plus multi-cycle sequences against behavioural masters
module tb_alt_dfe_ir_arbiter;
    typedef struct {
        int          rq;
        logic [15:0] ch;
        logic [15:0] wd;
        logic [15:0] wdat;
        logic        rwn;
        int          dly;
        logic [15:0] mrd;
        int          lat;
        logic        err;
        logic [15:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req, rwn, ack, grant;
    logic [31:0] ch, wd, wdat;
    logic        err, busy, trig, ir_rwn, ir_done;
    logic [15:0] rdata, ir_ch, ir_wd, ir_wdat, ir_rd;
    logic [0:0]  req2, rwn2, ack2, grant2;
    logic [15:0] ch2, wd2, wdat2, rdata2, ir_ch2, ir_wd2, ir_wdat2;
    logic        err2, busy2, trig2, ir_rwn2;
    int          mdly, mcnt, m2_cnt;
    logic        men, m_done, f_done, m2_done;
    logic [15:0] mdata, m_rd_l;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[6];
    int          lat, ntrig, tcyc, bad, n, a_n, t_n;
    logic [1:0]  g_at, ack_at;
    logic        err_at, rwn_at;
    logic [15:0] rd_at, ch_at, wd_at, wdat_at;
    logic [1:0]  order[4];
    int          tc[3], ac[3];

    always #5 clk = ~clk;

    alt_dfe_ir_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .i_avmm_clk(clk), .i_resetn(rstn), .i_req(req), .i_chaddress(ch), .i_wdaddress(wd),
        .i_writedata(wdat), .i_rwn(rwn), .o_ack(ack), .o_error(err), .o_readdata(rdata),
        .o_grant(grant), .o_busy(busy), .o_ir_trigger(trig), .o_ir_chaddress(ir_ch),
        .o_ir_wdaddress(ir_wd), .o_ir_writedata(ir_wdat), .o_ir_rwn(ir_rwn),
        .i_ir_done(ir_done), .i_ir_readdata(ir_rd)
    );

    alt_dfe_ir_arbiter #(.NUM_REQ(1), .TIMEOUT_CYCLES(8)) dut1 (
        .i_avmm_clk(clk), .i_resetn(rstn), .i_req(req2), .i_chaddress(ch2), .i_wdaddress(wd2),
        .i_writedata(wdat2), .i_rwn(rwn2), .o_ack(ack2), .o_error(err2), .o_readdata(rdata2),
        .o_grant(grant2), .o_busy(busy2), .o_ir_trigger(trig2), .o_ir_chaddress(ir_ch2),
        .o_ir_wdaddress(ir_wd2), .o_ir_writedata(ir_wdat2), .o_ir_rwn(ir_rwn2),
        .i_ir_done(m2_done), .i_ir_readdata(m2_done ? 16'h0077 : 16'hDEAD)
    );

    // master: done pulse mdly cycles after the trigger cycle, data only valid with done
    always @(posedge clk) begin
        if (!rstn) begin
            mcnt   <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (trig && men) begin
                if (mdly <= 1) begin
                    m_done <= 1'b1;
                    m_rd_l <= mdata;
                end else mcnt <= mdly - 1;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    m_done <= 1'b1;
                    m_rd_l <= mdata;
                end
            end
        end
    end
    assign ir_done = m_done | f_done;
    assign ir_rd   = m_done ? m_rd_l : f_done ? 16'hBEEF : 16'hDEAD;

    always @(posedge clk) begin
        if (!rstn) begin
            m2_cnt  <= 0;
            m2_done <= 1'b0;
        end else begin
            m2_done <= 1'b0;
            if (trig2) m2_cnt <= 1;
            else if (m2_cnt != 0) begin
                m2_cnt <= m2_cnt - 1;
                if (m2_cnt == 1) m2_done <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // {req, ch, wd, wdata, rwn, master delay, master data, ack latency, error, readdata}
        vecs[0] = '{0, 16'h0002, 16'h0001, 16'h0000, 1'b1, 5, 16'h000B, 7,  1'b0, 16'h000B};
        vecs[1] = '{1, 16'h0003, 16'h0004, 16'h1234, 1'b0, 2, 16'h0055, 4,  1'b0, 16'h0055};
        vecs[2] = '{0, 16'h0009, 16'h0008, 16'h0000, 1'b1, 0, 16'h1111, 10, 1'b1, 16'h0000};
        vecs[3] = '{1, 16'h00A0, 16'h00B0, 16'h0000, 1'b1, 8, 16'h0ABC, 10, 1'b0, 16'h0ABC};
        vecs[4] = '{0, 16'hFFFF, 16'h7FFF, 16'hAAAA, 1'b0, 7, 16'hFFFF, 9,  1'b0, 16'hFFFF};
        vecs[5] = '{1, 16'h0001, 16'h0002, 16'h5555, 1'b1, 2, 16'h0000, 4,  1'b0, 16'h0000};
        rstn = 1'b0; req = '0; ch = '0; wd = '0; wdat = '0; rwn = '0;
        men = 1'b0; mdly = 0; mdata = '0; f_done = 1'b0;
        req2 = '0; ch2 = 16'h0006; wd2 = 16'h0003; wdat2 = 16'h0011; rwn2 = '0;
        tick();
        check("rst flags", {ack, grant, err, busy, trig, ir_rwn}, 32'h0);
        check("rst readdata", rdata, 32'h0);
        check("rst ir_ch", ir_ch, 32'h0);
        check("rst ir_wd", ir_wd, 32'h0);
        check("rst ir_wdat", ir_wdat, 32'h0);
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            req[vecs[i].rq] = 1'b1;
            ch[vecs[i].rq*16 +: 16]   = vecs[i].ch;
            wd[vecs[i].rq*16 +: 16]   = vecs[i].wd;
            wdat[vecs[i].rq*16 +: 16] = vecs[i].wdat;
            rwn[vecs[i].rq] = vecs[i].rwn;
            mdly = vecs[i].dly; men = (vecs[i].dly != 0); mdata = vecs[i].mrd;
            lat = 0; ntrig = 0; tcyc = 0;
            for (int c = 1; c <= 30; c++) begin
                tick();
                if (trig) begin
                    ntrig++; tcyc = c; g_at = grant;
                    ch_at = ir_ch; wd_at = ir_wd; wdat_at = ir_wdat; rwn_at = ir_rwn;
                end
                if (ack != 0) begin
                    lat = c; ack_at = ack; err_at = err; rd_at = rdata;
                    req = '0;
                    break;
                end
            end
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d trig count", i), ntrig, 1);
            check($sformatf("v%0d trig cycle", i), tcyc, 1);
            check($sformatf("v%0d grant", i), g_at, 2'b01 << vecs[i].rq);
            check($sformatf("v%0d ack", i), ack_at, 2'b01 << vecs[i].rq);
            check($sformatf("v%0d error", i), err_at, vecs[i].err);
            check($sformatf("v%0d readdata", i), rd_at, vecs[i].rd);
            check($sformatf("v%0d ir fields", i), {ch_at, wd_at}, {vecs[i].ch, vecs[i].wd});
            check($sformatf("v%0d ir wdat rwn", i), {wdat_at, rwn_at}, {vecs[i].wdat, vecs[i].rwn});
            tick();
            check($sformatf("v%0d idle", i), {busy, grant, ack}, 32'h0);
        end

        // timeout then a late done while idle must be ignored
        req = 2'b01; men = 1'b0; lat = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ack != 0) begin
                lat = c; err_at = err; rd_at = rdata; req = '0;
                break;
            end
        end
        check("to latency", lat, 10);
        check("to error", err_at, 1'b1);
        check("to readdata", rd_at, 16'h0000);
        repeat (3) tick();
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (ack != 0 || busy || err) bad++;
        end
        check("late done ignored", bad, 0);
        check("late done readdata", rdata, 16'h0000);

        // command fields stay latched while requester changes them and drops its request
        req = 2'b10; ch[31:16] = 16'h0005; wd[31:16] = 16'h0002; wdat[31:16] = 16'h002D; rwn[1] = 1'b0;
        mdly = 6; men = 1'b1; mdata = 16'h0042; lat = 0; bad = 0; ack_at = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) begin
                ch[31:16] = 16'hFFFF; wd[31:16] = 16'hFFFF; wdat[31:16] = 16'hFFFF; rwn[1] = 1'b1;
                req = '0;
            end
            if (busy && {ir_ch, ir_wd, ir_wdat, ir_rwn} !== {16'h0005, 16'h0002, 16'h002D, 1'b0}) bad++;
            if (ack != 0) begin
                lat = c; ack_at = ack;
                break;
            end
        end
        check("stab fields", bad, 0);
        check("stab latency", lat, 8);
        check("stab ack", ack_at, 2'b10);
        tick();
        check("stab idle fields", {ir_ch, ir_wdat}, {16'h0005, 16'h002D});

        // reset during WAIT, then fairness from reset
        req = 2'b01; ch[15:0] = 16'h0007; mdly = 6;
        repeat (3) tick();
        check("pre-reset busy", busy, 1'b1);
        rstn = 1'b0; req = '0;
        tick();
        check("mid rst flags", {ack, grant, err, busy, trig, ir_rwn}, 32'h0);
        check("mid rst fields", {ir_ch, rdata}, 32'h0);
        rstn = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (ack != 0 || busy) bad++;
        end
        check("no ack after reset", bad, 0);
        req = 2'b11; mdly = 2; n = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (trig) begin
                order[n] = grant;
                n++;
                if (n == 4) begin
                    req = '0;
                    break;
                end
            end
        end
        check("fair count", n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("fair grant %0d", i), order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ack != 0) begin
                lat = c;
                break;
            end
        end
        check("fair last ack", lat, 3);

        // single requester, back-to-back writes
        req2 = 1'b1; t_n = 0; a_n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (trig2 && t_n < 3) begin
                tc[t_n] = c;
                t_n++;
            end
            if (ack2[0]) begin
                if (a_n < 3) ac[a_n] = c;
                a_n++;
                err_at = err2; rd_at = rdata2;
                if (a_n == 3) begin
                    req2 = 1'b0;
                    break;
                end
            end
        end
        check("single acks", a_n, 3);
        check("single trigs", t_n, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("single trig %0d", i), tc[i], 1 + 5 * i);
            check($sformatf("single ack %0d", i), ac[i], 4 + 5 * i);
        end
        check("single error", err_at, 1'b0);
        check("single readdata", rd_at, 16'h0077);
        bad = 0;
        repeat (6) begin
            tick();
            if (trig2 || ack2[0] || busy2) bad++;
        end
        check("single quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
